inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch stage directly upstream of the single-cycle datapath.
- Holds the PC and a loadable instruction memory; presents the current instruction to control/register/ALU decode.
- Computes the next PC from the sequential (PC+4), branch and jump paths.
- Advances only on a one-cycle `step` enable, so the core can run at the divided 1 Hz rate while sharing the single system clock.
- Provides a run/halt state machine and a retired-instruction counter for the 7-segment display path.

Parameters:
- ADDR_W, 6: word-address width of instruction memory (depth = 2^ADDR_W words).
- RESET_PC, 32'h0000_0000: PC value after reset.
- HALT_WORD, 32'hFC00_0000: instruction encoding (opcode 6'h3F) that halts fetch.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  leave IDLE and begin fetching.
- step  in  1  one-cycle enable; one instruction retires per asserted cycle in RUN.
- branch_taken  in  1  Branch AND Zero from the datapath.
- branch_offset  in  32  sign-extended immediate (words).
- jump  in  1  Jump from control.
- jump_index  in  26  instruction[25:0].
- imem_we  in  1  loader write enable.
- imem_waddr  in  ADDR_W  loader word address.
- imem_wdata  in  32  loader write data.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4 (mod 2^32).
- instruction  out  32  current instruction; 0 (NOP) when not RUN.
- valid  out  1  high in RUN.
- halted  out  1  high in HALT.
- inst_count  out  16  retired-instruction count.

Behaviour:
- Reset (rst low at a clock edge):
  - state=IDLE, pc=RESET_PC, inst_count=0, valid=0, halted=0.
  - Instruction memory contents are NOT cleared.
  - Reset wins over every other input in the same cycle.
- States:
  - IDLE→RUN: on start.
  - RUN→HALT: on step while the raw memory word at pc == HALT_WORD.
  - HALT exits only via reset.
- IDLE:
  - imem_we writes mem[imem_waddr] <= imem_wdata.
  - step ignored.
  - If start and imem_we arrive in the same cycle, the write is performed and the state becomes RUN.
- RUN/HALT: imem_we ignored (memory read-only).
- Read path:
  - Combinational read of mem[pc[ADDR_W+1:2]]; upper PC bits are ignored, so addresses alias/wrap modulo the memory depth.
  - pc[1:0] are always 0 by construction.
- Next PC (RUN, step=1, word != HALT_WORD), priority order:
  - jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - else branch_taken: pc_plus4 + (branch_offset << 2), 32-bit wrap.
  - else: pc_plus4.
  - jump and branch_taken both high → jump wins.
- PC hold conditions:
  - step=0 → pc holds; jump/branch inputs are don't-care.
  - Halt step → pc holds at the halt address and inst_count is not incremented.
- inst_count: +1 on each non-halt step in RUN; saturates at 16'hFFFF.
- instruction output: forced to 32'h0 in IDLE and HALT, so downstream RegWrite/MemWrite decode as 0.
- pc and pc_plus4 are visible in all states.
- Latency: new pc visible one clock after the step edge; instruction is valid combinationally in the same cycle.

Test Plan:
- Load and sequential fetch:
  - Stimulus: reset; load mem[0..3]=11111111,22222222,33333333,HALT_WORD; start; four steps.
  - Response: instruction sequence 11111111→22222222→33333333; pc 0→4→8→C.
  - After the fourth step: halted=1, pc=C, inst_count=3, instruction=0.
- Branch:
  - Stimulus: pc=4, branch_taken=1, branch_offset=32'hFFFF_FFFE, step.
  - Response: pc=0 (8 + -8).
  - Repeat with offset=3 → pc=14.
- Jump priority:
  - Stimulus: pc=8, jump=1, jump_index=26'h5, branch_taken=1, offset=1, step.
  - Response: pc=14 (jump wins).
- Step gating and write lockout:
  - Stimulus: in RUN, hold step=0 for 10 cycles with jump=1; pulse imem_we to addr 0 with data DEADBEEF.
  - Response: pc unchanged, inst_count unchanged, mem[0] unchanged.
- Reset mid-run and wrap:
  - Stimulus: assert rst low during RUN.
  - Response: next edge pc=0, IDLE, count=0, memory preserved; restart refetches the same words.
  - Stimulus: jump to index 26'h40 (pc=100).
  - Response: fetches mem[0] via alias.
- Counter saturation:
  - Stimulus: force inst_count=FFFF; one non-halt step.
  - Response: inst_count stays FFFF.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC register, loadable instruction memory, next-PC selection,
// run/halt control and a saturating retired-instruction counter.
module inst_fetch #(
  parameter int unsigned ADDR_W    = 6,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              step_i,
  input  logic              branch_taken_i,
  input  logic [31:0]       branch_offset_i,
  input  logic              jump_i,
  input  logic [25:0]       jump_index_i,
  input  logic              imem_we_i,
  input  logic [ADDR_W-1:0] imem_waddr_i,
  input  logic [31:0]       imem_wdata_i,
  output logic [31:0]       pc_o,
  output logic [31:0]       pc_plus4_o,
  output logic [31:0]       instruction_o,
  output logic              valid_o,
  output logic              halted_o,
  output logic [15:0]       inst_count_o
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q;
  logic        valid_q, halted_q;
  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] word;
  logic [31:0] pc_plus4;
  logic        is_halt;

  // Upper PC bits are dropped, so fetch addresses alias modulo the memory depth.
  assign word     = mem_q[pc_q[ADDR_W+1:2]];
  assign pc_plus4 = pc_q + 32'd4;
  assign is_halt  = (word == HALT_WORD);

  always_comb begin
    pc_d = pc_plus4;
    if (jump_i) begin
      pc_d = {pc_plus4[31:28], jump_index_i, 2'b00};
    end else if (branch_taken_i) begin
      pc_d = pc_plus4 + {branch_offset_i[29:0], 2'b00};
    end
  end

  // Memory is writable only from IDLE and is never cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && (state_q == StIdle) && imem_we_i) begin
      mem_q[imem_waddr_i] <= imem_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      cnt_q    <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StRun;
            valid_q <= 1'b1;
          end
        end
        StRun: begin
          if (step_i) begin
            if (is_halt) begin
              state_q  <= StHalt;
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_d;
              if (cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
              end
            end
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q  <= StIdle;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
  assign instruction_o = valid_q ? word : 32'h0000_0000;
  assign valid_o       = valid_q;
  assign halted_o      = halted_q;
  assign inst_count_o  = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed vector bench for inst_fetch: table of {inputs, expected outputs} plus hand sequences
// for step gating and counter saturation.
module tb_inst_fetch;

  localparam logic [31:0] Halt = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n, start, step, br, jmp, we;
  logic [31:0] off, wdata;
  logic [25:0] jidx;
  logic [5:0]  waddr;
  logic [31:0] pc, pc4, instr;
  logic        valid, halted;
  logic [15:0] cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_fetch #(
    .ADDR_W   (6),
    .RESET_PC (32'h0000_0000),
    .HALT_WORD(Halt)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .step_i         (step),
    .branch_taken_i (br),
    .branch_offset_i(off),
    .jump_i         (jmp),
    .jump_index_i   (jidx),
    .imem_we_i      (we),
    .imem_waddr_i   (waddr),
    .imem_wdata_i   (wdata),
    .pc_o           (pc),
    .pc_plus4_o     (pc4),
    .instruction_o  (instr),
    .valid_o        (valid),
    .halted_o       (halted),
    .inst_count_o   (cnt)
  );

  typedef struct {
    logic        rst_n, start, step, br;
    logic [31:0] off;
    logic        jmp;
    logic [25:0] jidx;
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] e_pc, e_instr;
    logic        e_valid, e_halted;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic st, logic b, logic [31:0] o, logic j,
                              logic [25:0] ji, logic w, logic [5:0] wa, logic [31:0] wd,
                              logic [31:0] epc, logic [31:0] ein, logic ev, logic eh,
                              logic [15:0] ec);
    vec_t v;
    v.rst_n = r; v.start = s; v.step = st; v.br = b; v.off = o; v.jmp = j; v.jidx = ji;
    v.we = w; v.waddr = wa; v.wdata = wd;
    v.e_pc = epc; v.e_instr = ein; v.e_valid = ev; v.e_halted = eh; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst_n = v.rst_n; start = v.start; step = v.step; br = v.br; off = v.off; jmp = v.jmp;
    jidx = v.jidx; we = v.we; waddr = v.waddr; wdata = v.wdata;
  endtask

  task automatic apply_check(vec_t v, int idx);
    drive(v);
    @(posedge clk);
    @(negedge clk);
    check("pc", idx, pc, v.e_pc);
    check("pc_plus4", idx, pc4, v.e_pc + 32'd4);
    check("instruction", idx, instr, v.e_instr);
    check("valid", idx, {31'd0, valid}, {31'd0, v.e_valid});
    check("halted", idx, {31'd0, halted}, {31'd0, v.e_halted});
    check("inst_count", idx, {16'd0, cnt}, {16'd0, v.e_cnt});
  endtask

  initial begin
    vec_t g;
    // Reset, load, sequential fetch to halt.
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,            32'h00,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,1,0,32'h11111111, 32'h00,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,1,1,32'h22222222, 32'h00,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,1,2,32'h33333333, 32'h00,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,1,3,Halt,         32'h00,32'h0,0,0,0));
    vecs.push_back(mk(1,0,1,0,0,0,0,0,0,0,            32'h00,32'h0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,0,0,            32'h00,32'h11111111,1,0,0));
    vecs.push_back(mk(1,0,1,0,0,0,0,0,0,0,            32'h04,32'h22222222,1,0,1));
    vecs.push_back(mk(1,0,1,0,0,0,0,0,0,0,            32'h08,32'h33333333,1,0,2));
    vecs.push_back(mk(1,0,1,0,0,0,0,0,0,0,            32'h0C,Halt,1,0,3));
    vecs.push_back(mk(1,0,1,0,0,0,0,0,0,0,            32'h0C,32'h0,0,1,3));
    vecs.push_back(mk(1,0,1,1,1,1,7,1,3,0,            32'h0C,32'h0,0,1,3));
    // Reset beats start and write in the same cycle.
    vecs.push_back(mk(0,1,1,0,0,0,0,1,0,0,            32'h00,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,1,4,32'h44444444, 32'h00,32'h0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,0,1,5,32'h55555555, 32'h00,32'h11111111,1,0,0));
    // Branches, jump, jump priority, alias.
    vecs.push_back(mk(1,0,1,0,0,0,0,0,0,0,            32'h04,32'h22222222,1,0,1));
    vecs.push_back(mk(1,0,1,1,32'hFFFFFFFE,0,0,0,0,0, 32'h00,32'h11111111,1,0,2));
    vecs.push_back(mk(1,0,1,0,0,0,0,0,0,0,            32'h04,32'h22222222,1,0,3));
    vecs.push_back(mk(1,0,1,1,3,0,0,0,0,0,            32'h14,32'h55555555,1,0,4));
    vecs.push_back(mk(1,0,1,0,0,1,2,0,0,0,            32'h08,32'h33333333,1,0,5));
    vecs.push_back(mk(1,0,1,1,1,1,5,0,0,0,            32'h14,32'h55555555,1,0,6));
    vecs.push_back(mk(1,0,1,0,0,1,26'h40,0,0,0,       32'h100,32'h11111111,1,0,7));
    vecs.push_back(mk(1,0,1,0,0,0,0,0,0,0,            32'h104,32'h22222222,1,0,8));

    rst_n = 1'b0; start = 0; step = 0; br = 0; off = 0; jmp = 0; jidx = 0;
    we = 0; waddr = 0; wdata = 0;
    @(negedge clk);
    foreach (vecs[i]) apply_check(vecs[i], i);

    // Step held low with jump high and a write attempt while running.
    g = mk(1,0,0,1,1,1,0,1,0,32'hDEADBEEF, 32'h104,32'h22222222,1,0,8);
    for (int k = 0; k < 10; k++) apply_check(g, 100 + k);
    apply_check(mk(1,0,1,0,0,1,0,0,0,0,      32'h00,32'h11111111,1,0,9), 110);

    // Reset mid-run preserves memory; restart refetches.
    apply_check(mk(0,0,1,0,0,0,0,0,0,0,      32'h00,32'h0,0,0,0), 120);
    apply_check(mk(1,1,0,0,0,0,0,0,0,0,      32'h00,32'h11111111,1,0,0), 121);
    apply_check(mk(1,0,1,0,0,0,0,0,0,0,      32'h04,32'h22222222,1,0,1), 122);

    // Drive the counter to saturation by looping on address 0.
    drive(mk(1,0,1,0,0,1,0,0,0,0, 0,0,0,0,0));
    for (int k = 0; k < 65533; k++) @(posedge clk);
    apply_check(mk(1,0,1,0,0,1,0,0,0,0,      32'h00,32'h11111111,1,0,16'hFFFF), 130);
    apply_check(mk(1,0,1,0,0,1,0,0,0,0,      32'h00,32'h11111111,1,0,16'hFFFF), 131);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
